// File: rtl/slug_pkg.sv
// Shared types and constants for the SlugCross input path.
package slug_pkg;

    typedef enum logic [0:0] {SEQ_HOLD, SEQ_RUN} seq_state_t;

    localparam int unsigned NBTN = 5;

    // Button bit positions, {C,U,D,L,R} = [4:0]
    localparam int unsigned BTN_R = 0;
    localparam int unsigned BTN_L = 1;
    localparam int unsigned BTN_D = 2;
    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_C = 4;

endpackage

// File: rtl/vbl_timeout_ctr.sv
// Saturating cycle counter; hit flags that the count has reached LIMIT-1.
module vbl_timeout_ctr #(
    parameter int unsigned LIMIT = 2000000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] THR = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != THR)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit = (cnt == THR);

endmodule

// File: rtl/game_input_sequencer.sv
// Owns the game core's reset, difficulty and buttons: frame-count reset hold,
// per-frame button latching with tap capture, and release on VBlank loss.
module game_input_sequencer #(
    parameter int unsigned RST_HOLD_FRAMES = 4,
    parameter int unsigned VBL_TIMEOUT     = 2000000,
    parameter int unsigned NBTN            = slug_pkg::NBTN
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            vblank,
    input  logic [NBTN-1:0] joy_in,
    input  logic [1:0]      diff_cfg,
    input  logic            soft_reset,
    output logic            game_rst,
    output logic [NBTN-1:0] btn_out,
    output logic [1:0]      diff_out,
    output logic [15:0]     frame_cnt,
    output logic            vbl_lost
);

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_FRAMES - 1);

    slug_pkg::seq_state_t state;
    logic                 vbl_q;
    logic                 vbl_rise;
    logic                 tmo_hit;
    logic                 tmo_clr;
    logic [7:0]           hold_cnt;
    logic [NBTN-1:0]      sticky;

    assign vbl_rise = vblank & ~vbl_q;
    assign tmo_clr  = (state == slug_pkg::SEQ_HOLD) || vbl_rise || soft_reset;

    vbl_timeout_ctr #(
        .LIMIT (VBL_TIMEOUT)
    ) u_tmo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clr     (tmo_clr),
        .en      (state == slug_pkg::SEQ_RUN),
        .hit     (tmo_hit)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vbl_q <= 1'b0;
        end else begin
            vbl_q <= vblank;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= slug_pkg::SEQ_HOLD;
            game_rst  <= 1'b1;
            btn_out   <= '0;
            diff_out  <= 2'b00;
            frame_cnt <= 16'd0;
            vbl_lost  <= 1'b0;
            hold_cnt  <= 8'd0;
            sticky    <= '0;
        end else if (soft_reset) begin
            // Overrides any same-cycle VBlank edge: no latch, no hold count.
            state    <= slug_pkg::SEQ_HOLD;
            game_rst <= 1'b1;
            btn_out  <= '0;
            diff_out <= diff_cfg;
            vbl_lost <= 1'b0;
            hold_cnt <= 8'd0;
            sticky   <= '0;
        end else begin
            case (state)
                slug_pkg::SEQ_HOLD: begin
                    game_rst <= 1'b1;
                    btn_out  <= '0;
                    diff_out <= diff_cfg;
                    vbl_lost <= 1'b0;
                    sticky   <= '0;
                    if (vbl_rise) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= slug_pkg::SEQ_RUN;
                            game_rst <= 1'b0;
                            hold_cnt <= 8'd0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                slug_pkg::SEQ_RUN: begin
                    if (diff_cfg != diff_out) begin
                        state    <= slug_pkg::SEQ_HOLD;
                        game_rst <= 1'b1;
                        btn_out  <= '0;
                        diff_out <= diff_cfg;
                        vbl_lost <= 1'b0;
                        hold_cnt <= 8'd0;
                        sticky   <= '0;
                    end else if (vbl_rise) begin
                        btn_out   <= sticky | joy_in;
                        sticky    <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                        vbl_lost  <= 1'b0;
                    end else if (tmo_hit) begin
                        // Frames stopped: drop everything until VBlank returns.
                        vbl_lost <= 1'b1;
                        btn_out  <= '0;
                        sticky   <= '0;
                    end else begin
                        sticky <= sticky | joy_in;
                    end
                end
                default: begin
                    state <= slug_pkg::SEQ_HOLD;
                end
            endcase
        end
    end

endmodule

// File: doc/game_input_sequencer.md
Name: game_input_sequencer

Overview:
- Sits between the HPS joystick/OSD status and the SlugCross game core in the emu wrapper; owns the core's reset, difficulty configuration and button inputs.
- Holds the game in reset for a fixed number of video frames after any reset or difficulty change.
- Samples joystick inputs once per frame at VBlank onset, with per-frame press capture so short taps are never lost.
- Releases all inputs if VBlank stops arriving.

Parameters:
- RST_HOLD_FRAMES, 4, number of VBlank rising edges game_rst stays high after entering HOLD; legal range 1..255.
- VBL_TIMEOUT, 2000000, clk_sys cycles without a VBlank rising edge before inputs are released.
- NBTN, 5, number of button bits, ordered {C,U,D,L,R} = [4:0].

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- vblank  in  1  game core VBlank, synchronous to clk_sys.
- joy_in  in  NBTN  raw joystick buttons, active-high.
- diff_cfg  in  2  requested difficulty (OSD status bits [3:2]).
- soft_reset  in  1  active-high request from OSD or the user button; level-sensitive.
- game_rst  out  1  active-high reset to the game core.
- btn_out  out  NBTN  frame-latched buttons to the game core.
- diff_out  out  2  difficulty applied to the game core; stable while game_rst=0.
- frame_cnt  out  16  VBlank rising edges counted in RUN; wraps 0xFFFF->0.
- vbl_lost  out  1  high while the VBlank timeout is active.

Behaviour:
- Reset values while reset_n=0: state=HOLD, game_rst=1, btn_out=0, diff_out=0, frame_cnt=0, vbl_lost=0, hold_cnt=0, sticky=0, tmo_cnt=0, vbl_q=0.
- VBlank edge: vbl_q <= vblank every cycle; vbl_rise = vblank & ~vbl_q. All edge actions take effect on the clock edge where vbl_rise=1 and are visible one cycle later.
- FSM states: HOLD, RUN.
- HOLD:
  - game_rst=1, btn_out=0, sticky=0, vbl_lost=0; diff_out <= diff_cfg every cycle.
  - Each vbl_rise increments hold_cnt.
  - On the vbl_rise that makes hold_cnt reach RST_HOLD_FRAMES: go to RUN. game_rst=0 from the next cycle; hold_cnt and tmo_cnt clear.
- RUN:
  - Each cycle, sticky <= sticky | joy_in.
  - On vbl_rise: btn_out <= sticky | joy_in; sticky <= 0; frame_cnt++; tmo_cnt <= 0; vbl_lost <= 0.
  - A button held continuously therefore stays 1. A tap of at least one cycle appears for exactly one frame.
- Timeout: in RUN, tmo_cnt increments each cycle without vbl_rise. When it reaches VBL_TIMEOUT-1: vbl_lost <= 1, btn_out <= 0, sticky <= 0, and tmo_cnt saturates. The next vbl_rise resumes normal latching.
- RUN -> HOLD transitions, both taking effect next cycle with hold_cnt <= 0:
  - soft_reset=1 in any state: forced HOLD, hold_cnt held at 0 while soft_reset stays high.
  - diff_cfg != diff_out while in RUN.
- frame_cnt is not cleared by soft_reset; only reset_n clears it.
- Simultaneous events:
  - soft_reset with vbl_rise: soft_reset wins; no latch, no hold_cnt increment.
  - Difficulty change with vbl_rise in RUN: HOLD wins; btn_out is cleared, not latched.
  - vbl_rise with the timeout threshold in the same cycle: vbl_rise wins.
- reset_n asserted mid-frame: all state clears immediately (async). After deassert, the full RST_HOLD_FRAMES hold sequence runs.
- Widths: hold_cnt is 8 bits; tmo_cnt is $clog2(VBL_TIMEOUT+1) bits.

Decomposition:
- Shared package slug_pkg:
  - typedef enum logic [0:0] {SEQ_HOLD, SEQ_RUN} seq_state_t.
  - Button index constants BTN_R=0, BTN_L=1, BTN_D=2, BTN_U=3, BTN_C=4.
  - NBTN default.
- One sub-module: vbl_timeout_ctr (saturating counter with clear and threshold flag).
- Edge detect, sticky capture and FSM stay in the top.

Test Plan:
- Reset then 4 vblank pulses (period 1000 cycles) -> game_rst=1 until the cycle after the 4th rise, then 0; diff_out equals diff_cfg=2'b10; frame_cnt=0.
- In RUN, joy_in[4] pulsed for 1 cycle mid-frame -> btn_out=5'b10000 for exactly one frame after the next rise, then 0. joy_in[0] held for 3 frames -> btn_out[0]=1 for 3 frames.
- In RUN, diff_cfg changes 01->11 -> game_rst=1 next cycle, btn_out=0, diff_out=11, 4-frame hold, then RUN; frame_cnt is retained.
- soft_reset asserted in the same cycle as vbl_rise -> no latch, frame_cnt unchanged, HOLD entered; hold counting starts only after soft_reset drops.
- VBL_TIMEOUT=100, vblank stopped with joy_in=5'b01000 -> vbl_lost=1 and btn_out=0 after 100 cycles. A vblank pulse then restarts latching: btn_out=01000, vbl_lost=0.
- reset_n pulsed low mid-RUN -> all outputs at reset values asynchronously; frame_cnt=0; full hold sequence repeats.
